symbolic_qkd_reader: RTL and testbench

- Initiator side of the read-once QKD register interface.
- Scans NUM_CELLS register cells in order. For each cell it takes a host-supplied basis/phase guess, presents its metadata, and issues exactly one single-cycle read strobe.
- Captures value_in when the cell grants output_enable and streams accepted bytes out through a KEY_BYTES-deep FIFO.
- Sits between the host/key-sifting logic and a bank of symbolic_qkd_register cells; each cell collapses on first read, so there is never a retry.

---
 rtl/symbolic_qkd_reader.sv | 159 +++++++++++++++
 tb/tb_symbolic_qkd_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/symbolic_qkd_reader.sv
// symbolic_qkd_reader: scans read-once QKD cells, strobes each exactly once and queues accepted bytes.
// Define QKD_READER_PAD_CHECK_EN to require pad_en_in alongside oe_in for acceptance.
module symbolic_qkd_reader #(
    parameter int NUM_CELLS = 4,
    parameter int KEY_BYTES = 4,
    parameter logic [3:0] READER_ID = 4'hA
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         guess_valid,
    output logic                         guess_ready,
    input  logic [1:0]                   guess_basis,
    input  logic [1:0]                   guess_phase,
    output logic [$clog2(NUM_CELLS)-1:0] cell_sel,
    output logic                         read,
    output logic [1:0]                   basis_out,
    output logic [1:0]                   phase_out,
    output logic [3:0]                   identity_out,
    output logic [7:0]                   time_out,
    input  logic [7:0]                   value_in,
    input  logic                         oe_in,
    input  logic                         pad_en_in,
    output logic                         key_valid,
    output logic [7:0]                   key_data,
    input  logic                         key_ready,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   ok_count,
    output logic [7:0]                   fail_count
);
    localparam int CW = $clog2(NUM_CELLS);
    localparam int PW = $clog2(KEY_BYTES);
    typedef enum logic [2:0] {IDLE, ARM, STROBE, EVAL, HOLD} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] sel_q, sel_d;
    logic [1:0] basis_q, basis_d, phase_q, phase_d;
    logic [7:0] time_q, hold_q, hold_d, ok_q, ok_d, fail_q, fail_d;
    logic read_q, acc_q, acc_d, done_q, done_d, adv, push, pop, full, empty, accept, last;
    logic [PW:0] wr_q, rd_q;
    logic [7:0] mem_q [KEY_BYTES];
`ifdef QKD_READER_PAD_CHECK_EN
    assign accept = oe_in & pad_en_in;
`else
    assign accept = oe_in;
`endif
    assign empty = wr_q == rd_q;
    assign full = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop = !empty && key_ready;
    assign last = sel_q == CW'(NUM_CELLS - 1);
    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        basis_d = basis_q;
        phase_d = phase_q;
        hold_d = hold_q;
        acc_d = acc_q;
        ok_d = ok_q;
        fail_d = fail_q;
        done_d = 1'b0;
        adv = 1'b0;
        push = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                ok_d = 8'd0;
                fail_d = 8'd0;
                sel_d = '0;
                state_d = ARM;
            end
            ARM: if (guess_valid) begin
                basis_d = guess_basis;
                phase_d = guess_phase;
                state_d = STROBE;
            end
            STROBE: begin
                acc_d = accept;
                hold_d = value_in;
                state_d = EVAL;
            end
            EVAL: if (!acc_q) begin
                fail_d = fail_q == 8'hFF ? fail_q : fail_q + 8'd1;
                adv = 1'b1;
            end else if (!full) begin
                push = 1'b1;
                adv = 1'b1;
            end else begin
                state_d = HOLD;
            end
            HOLD: if (!full || pop) begin
                push = 1'b1;
                adv = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (push) ok_d = ok_q == 8'hFF ? ok_q : ok_q + 8'd1;
        if (adv) begin
            state_d = last ? IDLE : ARM;
            done_d = last;
            sel_d = last ? sel_q : sel_q + CW'(1);
        end
        // abort wins everywhere: captured data is dropped and no completion is reported
        if (abort) begin
            state_d = IDLE;
            done_d = 1'b0;
            push = 1'b0;
            sel_d = sel_q;
            ok_d = ok_q;
            fail_d = fail_q;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q <= '0;
            basis_q <= 2'd0;
            phase_q <= 2'd0;
            time_q <= 8'd0;
            hold_q <= 8'd0;
            acc_q <= 1'b0;
            ok_q <= 8'd0;
            fail_q <= 8'd0;
            read_q <= 1'b0;
            done_q <= 1'b0;
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            basis_q <= basis_d;
            phase_q <= phase_d;
            time_q <= time_q + 8'd1;
            hold_q <= hold_d;
            acc_q <= acc_d;
            ok_q <= ok_d;
            fail_q <= fail_d;
            read_q <= state_d == STROBE;
            done_q <= done_d;
            wr_q <= push ? wr_q + (PW+1)'(1) : wr_q;
            rd_q <= pop ? rd_q + (PW+1)'(1) : rd_q;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[PW-1:0]] <= hold_q;
    end
    assign guess_ready = state_q == ARM;
    assign cell_sel = sel_q;
    assign read = read_q;
    assign basis_out = basis_q;
    assign phase_out = phase_q;
    assign identity_out = READER_ID;
    assign time_out = time_q;
    assign key_valid = !empty;
    assign key_data = mem_q[rd_q[PW-1:0]];
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign ok_count = ok_q;
    assign fail_count = fail_q;
endmodule

// File: tb/tb_symbolic_qkd_reader.sv
// tb_symbolic_qkd_reader: directed checks of the QKD reader against a four-cell model, two-deep FIFO.
module tb_symbolic_qkd_reader;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, gv = 1'b0, key_ready = 1'b1;
    logic guess_ready, read, key_valid, busy, done, oe_in, pad_en_in;
    logic [1:0] cell_sel, basis_out, phase_out, guess_basis, guess_phase;
    logic [3:0] identity_out;
    logic [7:0] time_out, value_in, key_data, ok_count, fail_count;
    logic [1:0] cb [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] cp [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
    logic [1:0] gb [4], gp [4];
    logic [7:0] vals [4] = '{8'h3C, 8'h5A, 8'h99, 8'hF0};
    logic pad [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] q [$];
    int total = 0, bad = 0, rd_cnt = 0, done_cnt = 0, consec = 0;
    logic prev_read = 1'b0;

    always #5 clk = ~clk;
    assign guess_basis = gb[cell_sel];
    assign guess_phase = gp[cell_sel];
    assign value_in = vals[cell_sel];
    assign oe_in = basis_out == cb[cell_sel] && phase_out == cp[cell_sel];
    assign pad_en_in = pad[cell_sel];

    symbolic_qkd_reader #(.NUM_CELLS(4), .KEY_BYTES(2), .READER_ID(4'hA)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .guess_valid(gv), .guess_ready(guess_ready), .guess_basis(guess_basis), .guess_phase(guess_phase),
        .cell_sel(cell_sel), .read(read), .basis_out(basis_out), .phase_out(phase_out),
        .identity_out(identity_out), .time_out(time_out), .value_in(value_in), .oe_in(oe_in),
        .pad_en_in(pad_en_in), .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
        .busy(busy), .done(done), .ok_count(ok_count), .fail_count(fail_count)
    );

    always @(negedge clk) begin
        if (read) rd_cnt++;
        if (read && prev_read) consec++;
        prev_read = read;
        if (done) done_cnt++;
        if (key_valid && key_ready) q.push_back(key_data);
    end

    task automatic clear_run();
        rd_cnt = 0;
        done_cnt = 0;
        q = {};
        for (int i = 0; i < 4; i++) begin
            gb[i] = cb[i];
            gp[i] = cp[i];
            pad[i] = 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < 300);
        timed_out = busy;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #23;
        total++; if (read !== 1'b0 || guess_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_strobes got read=%b gr=%b done=%b exp 0", read, guess_ready, done); end
        total++; if (cell_sel !== 2'd0 || basis_out !== 2'd0 || phase_out !== 2'd0) begin bad++; $display("FAIL reset_meta got sel=%h b=%h p=%h exp 0", cell_sel, basis_out, phase_out); end
        total++; if (time_out !== 8'd0 || key_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_misc got t=%h kv=%b busy=%b exp 0", time_out, key_valid, busy); end
        total++; if (ok_count !== 8'd0 || fail_count !== 8'd0) begin bad++; $display("FAIL reset_counts got ok=%0d fail=%0d exp 0", ok_count, fail_count); end
        total++; if (identity_out !== 4'hA) begin bad++; $display("FAIL identity got=%h exp=a", identity_out); end
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_all_match();
        bit to;
        clear_run();
        gv = 1'b1;
        pulse_start();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL all_match_timeout got busy=1 exp busy=0"); end
        total++; if (q.size() !== 4) begin bad++; $display("FAIL all_match_size got=%0d exp=4", q.size()); end
        else for (int i = 0; i < 4; i++) begin
            total++; if (q[i] !== vals[i]) begin bad++; $display("FAIL all_match_byte%0d got=%h exp=%h", i, q[i], vals[i]); end
        end
        total++; if (ok_count !== 8'd4 || fail_count !== 8'd0) begin bad++; $display("FAIL all_match_counts got ok=%0d fail=%0d exp 4/0", ok_count, fail_count); end
        total++; if (done_cnt !== 1 || rd_cnt !== 4) begin bad++; $display("FAIL all_match_pulses got done=%0d reads=%0d exp 1/4", done_cnt, rd_cnt); end
    endtask

    task automatic test_wrong_guess();
        bit to;
        clear_run();
        gb[1] = 2'd0;
        gp[3] = 2'd0;
        pulse_start();
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL wrong_timeout got busy=1 exp busy=0"); end
        total++; if (q.size() !== 2 || q[0] !== 8'h3C || q[1] !== 8'h99) begin bad++; $display("FAIL wrong_bytes got n=%0d exp 2 bytes 3c,99", q.size()); end
        total++; if (ok_count !== 8'd2 || fail_count !== 8'd2) begin bad++; $display("FAIL wrong_counts got ok=%0d fail=%0d exp 2/2", ok_count, fail_count); end
        total++; if (rd_cnt !== 4) begin bad++; $display("FAIL wrong_reads got=%0d exp=4", rd_cnt); end
    endtask

    task automatic test_hold();
        bit to;
        clear_run();
        key_ready = 1'b0;
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1 || cell_sel !== 2'd2) begin bad++; $display("FAIL hold_park got busy=%b sel=%0d exp 1/2", busy, cell_sel); end
        total++; if (rd_cnt !== 3 || key_data !== 8'h3C || key_valid !== 1'b1) begin bad++; $display("FAIL hold_state got reads=%0d head=%h kv=%b exp 3/3c/1", rd_cnt, key_data, key_valid); end
        key_ready = 1'b1;
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL hold_timeout got busy=1 exp busy=0"); end
        total++; if (q.size() !== 4) begin bad++; $display("FAIL hold_size got=%0d exp=4", q.size()); end
        else for (int i = 0; i < 4; i++) begin
            total++; if (q[i] !== vals[i]) begin bad++; $display("FAIL hold_byte%0d got=%h exp=%h", i, q[i], vals[i]); end
        end
        total++; if (ok_count !== 8'd4) begin bad++; $display("FAIL hold_ok got=%0d exp=4", ok_count); end
    endtask

    task automatic test_arm_wait();
        bit to;
        logic [7:0] t0;
        clear_run();
        gv = 1'b0;
        pulse_start();
        t0 = time_out;
        repeat (20) @(posedge clk);
        #1;
        total++; if (rd_cnt !== 0 || read !== 1'b0 || guess_ready !== 1'b1) begin bad++; $display("FAIL arm_wait got reads=%0d read=%b gr=%b exp 0/0/1", rd_cnt, read, guess_ready); end
        total++; if (time_out !== t0 + 8'd20) begin bad++; $display("FAIL arm_time got=%h exp=%h", time_out, t0 + 8'd20); end
        gv = 1'b1;
        @(posedge clk); #1;
        total++; if (read !== 1'b1) begin bad++; $display("FAIL arm_latency got read=%b exp=1", read); end
        wait_idle(to);
        total++; if (to || ok_count !== 8'd4) begin bad++; $display("FAIL arm_finish got busy=%b ok=%0d exp 0/4", busy, ok_count); end
    endtask

    task automatic test_abort();
        bit to;
        int n = 0;
        clear_run();
        pulse_start();
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(read && cell_sel == 2'd1) && n < 50);
        total++; if (n >= 50) begin bad++; $display("FAIL abort_reach got no strobe on cell 1 exp strobe"); end
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        total++; if (busy !== 1'b0 || read !== 1'b0) begin bad++; $display("FAIL abort_idle got busy=%b read=%b exp 0/0", busy, read); end
        repeat (4) @(posedge clk);
        #1;
        total++; if (done_cnt !== 0 || rd_cnt !== 2 || consec !== 0) begin bad++; $display("FAIL abort_pulses got done=%0d reads=%0d consec=%0d exp 0/2/0", done_cnt, rd_cnt, consec); end
        total++; if (q.size() !== 1 || ok_count !== 8'd1) begin bad++; $display("FAIL abort_push got n=%0d ok=%0d exp 1/1", q.size(), ok_count); end
        pulse_start();
        total++; if (busy !== 1'b1 || cell_sel !== 2'd0) begin bad++; $display("FAIL abort_restart got busy=%b sel=%0d exp 1/0", busy, cell_sel); end
        wait_idle(to);
        total++; if (to || ok_count !== 8'd4 || q.size() !== 5) begin bad++; $display("FAIL abort_rerun got ok=%0d n=%0d exp 4/5", ok_count, q.size()); end
    endtask

    task automatic test_pad();
        bit to;
        clear_run();
        pad[0] = 1'b0;
        pulse_start();
        wait_idle(to);
`ifdef QKD_READER_PAD_CHECK_EN
        total++; if (fail_count !== 8'd1 || q.size() !== 3 || q[0] !== 8'h5A) begin bad++; $display("FAIL pad_check got fail=%0d n=%0d exp 1/3", fail_count, q.size()); end
`else
        total++; if (fail_count !== 8'd0 || q.size() !== 4 || q[0] !== 8'h3C) begin bad++; $display("FAIL pad_ignore got fail=%0d n=%0d exp 0/4", fail_count, q.size()); end
`endif
    endtask

    task automatic test_async_reset();
        clear_run();
        key_ready = 1'b0;
        pulse_start();
        repeat (5) @(posedge clk);
        #2;
        total++; if (key_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL areset_pre got kv=%b busy=%b exp 1/1", key_valid, busy); end
        reset_n = 1'b0;
        #1;
        total++; if (key_valid !== 1'b0 || busy !== 1'b0 || read !== 1'b0 || ok_count !== 8'd0 || time_out !== 8'd0 || cell_sel !== 2'd0) begin bad++; $display("FAIL areset_now got kv=%b busy=%b read=%b ok=%0d t=%h sel=%0d exp all 0", key_valid, busy, read, ok_count, time_out, cell_sel); end
        @(negedge clk) reset_n = 1'b1;
        key_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_all_match();
        test_wrong_guess();
        test_hold();
        test_arm_wait();
        test_abort();
        test_pad();
        test_async_reset();
        total++; if (consec !== 0) begin bad++; $display("FAIL read_back_to_back got=%0d exp=0", consec); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
